// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI write-path arbiter.
package axi_arb_pkg;

  localparam int unsigned DefIdW   = 4;
  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 32;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StResp
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not own the bus last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_idx,
  output logic       gnt_valid
);

  assign gnt_valid = |req;
  assign gnt_idx   = (&req) ? ~last : req[1];

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-to-one AXI write arbiter; grant held from AW handshake through B handshake,
// with WLAST toward the slave regenerated from AWLEN.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned ID_W   = DefIdW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   m0_AWID,
  input  logic [ADDR_W-1:0] m0_AWADDR,
  input  logic [7:0]        m0_AWLEN,
  input  logic [2:0]        m0_AWSIZE,
  input  logic [1:0]        m0_AWBURST,
  input  logic              m0_AWVALID,
  output logic              m0_AWREADY,
  input  logic [ID_W-1:0]   m0_WID,
  input  logic [DATA_W-1:0] m0_WDATA,
  input  logic [DATA_W/8-1:0] m0_WSTRB,
  input  logic              m0_WLAST,
  input  logic              m0_WVALID,
  output logic              m0_WREADY,
  output logic [ID_W-1:0]   m0_BID,
  output logic [1:0]        m0_BRESP,
  output logic              m0_BVALID,
  input  logic              m0_BREADY,
  input  logic [ID_W-1:0]   m1_AWID,
  input  logic [ADDR_W-1:0] m1_AWADDR,
  input  logic [7:0]        m1_AWLEN,
  input  logic [2:0]        m1_AWSIZE,
  input  logic [1:0]        m1_AWBURST,
  input  logic              m1_AWVALID,
  output logic              m1_AWREADY,
  input  logic [ID_W-1:0]   m1_WID,
  input  logic [DATA_W-1:0] m1_WDATA,
  input  logic [DATA_W/8-1:0] m1_WSTRB,
  input  logic              m1_WLAST,
  input  logic              m1_WVALID,
  output logic              m1_WREADY,
  output logic [ID_W-1:0]   m1_BID,
  output logic [1:0]        m1_BRESP,
  output logic              m1_BVALID,
  input  logic              m1_BREADY,
  output logic [ID_W-1:0]   s_AWID,
  output logic [ADDR_W-1:0] s_AWADDR,
  output logic [7:0]        s_AWLEN,
  output logic [2:0]        s_AWSIZE,
  output logic [1:0]        s_AWBURST,
  output logic              s_AWVALID,
  input  logic              s_AWREADY,
  output logic [ID_W-1:0]   s_WID,
  output logic [DATA_W-1:0] s_WDATA,
  output logic [DATA_W/8-1:0] s_WSTRB,
  output logic              s_WLAST,
  output logic              s_WVALID,
  input  logic              s_WREADY,
  input  logic [ID_W-1:0]   s_BID,
  input  logic [1:0]        s_BRESP,
  input  logic              s_BVALID,
  output logic              s_BREADY,
  output logic              grant,
  output logic              busy,
  output logic              wlast_err
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;

  logic gnt_idx, gnt_valid;
  logic aw_valid_sel, w_valid_sel, w_last_sel, b_ready_sel;
  logic beat_last;

  rr_arb2 u_rr_arb2 (
    .req       ({m1_AWVALID, m0_AWVALID}),
    .last      (last_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Payload fields follow the owner unconditionally; only valids/readies are state-gated.
  assign s_AWID    = grant_q ? m1_AWID    : m0_AWID;
  assign s_AWADDR  = grant_q ? m1_AWADDR  : m0_AWADDR;
  assign s_AWLEN   = grant_q ? m1_AWLEN   : m0_AWLEN;
  assign s_AWSIZE  = grant_q ? m1_AWSIZE  : m0_AWSIZE;
  assign s_AWBURST = grant_q ? m1_AWBURST : m0_AWBURST;
  assign s_WID     = grant_q ? m1_WID     : m0_WID;
  assign s_WDATA   = grant_q ? m1_WDATA   : m0_WDATA;
  assign s_WSTRB   = grant_q ? m1_WSTRB   : m0_WSTRB;

  assign aw_valid_sel = grant_q ? m1_AWVALID : m0_AWVALID;
  assign w_valid_sel  = grant_q ? m1_WVALID  : m0_WVALID;
  assign w_last_sel   = grant_q ? m1_WLAST   : m0_WLAST;
  assign b_ready_sel  = grant_q ? m1_BREADY  : m0_BREADY;

  assign m0_BID   = s_BID;
  assign m0_BRESP = s_BRESP;
  assign m1_BID   = s_BID;
  assign m1_BRESP = s_BRESP;

  assign beat_last = (beat_cnt_q == 8'd0);
  assign grant     = grant_q;
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    s_AWVALID  = 1'b0;
    s_WVALID   = 1'b0;
    s_WLAST    = 1'b0;
    s_BREADY   = 1'b0;
    m0_AWREADY = 1'b0;
    m1_AWREADY = 1'b0;
    m0_WREADY  = 1'b0;
    m1_WREADY  = 1'b0;
    m0_BVALID  = 1'b0;
    m1_BVALID  = 1'b0;
    wlast_err  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          grant_d = gnt_idx;
          state_d = StAddr;
        end
      end
      StAddr: begin
        s_AWVALID  = aw_valid_sel;
        m0_AWREADY = ~grant_q & s_AWREADY;
        m1_AWREADY = grant_q & s_AWREADY;
        if (aw_valid_sel && s_AWREADY) begin
          beat_cnt_d = s_AWLEN;
          state_d    = StData;
        end
      end
      StData: begin
        s_WVALID  = w_valid_sel;
        s_WLAST   = beat_last;
        m0_WREADY = ~grant_q & s_WREADY;
        m1_WREADY = grant_q & s_WREADY;
        if (w_valid_sel && s_WREADY) begin
          wlast_err = (w_last_sel != beat_last);
          if (beat_last) state_d = StResp;
          else           beat_cnt_d = beat_cnt_q - 8'd1;
        end
      end
      StResp: begin
        s_BREADY  = b_ready_sel;
        m0_BVALID = ~grant_q & s_BVALID;
        m1_BVALID = grant_q & s_BVALID;
        if (s_BVALID && b_ready_sel) begin
          last_d  = grant_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= StIdle;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      beat_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: arbitration order, beat framing, wlast_err and reset.
module tb_axi_wr_arbiter;
  import axi_arb_pkg::*;

  logic clk = 1'b0;
  logic ARESETn;
  always #5 clk = ~clk;

  logic [3:0]  awid   [2];
  logic [31:0] awaddr [2];
  logic [7:0]  awlen  [2];
  logic [2:0]  awsize [2];
  logic [1:0]  awburst[2];
  logic        awvalid[2];
  logic        awready[2];
  logic [3:0]  wid    [2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic        wlast  [2];
  logic        wvalid [2];
  logic        wready [2];
  logic [3:0]  bid    [2];
  logic [1:0]  bresp  [2];
  logic        bvalid [2];
  logic        bready [2];

  logic [3:0]  s_AWID, s_WID, s_BID;
  logic [31:0] s_AWADDR, s_WDATA;
  logic [7:0]  s_AWLEN;
  logic [2:0]  s_AWSIZE;
  logic [1:0]  s_AWBURST, s_BRESP;
  logic [3:0]  s_WSTRB;
  logic        s_AWVALID, s_AWREADY, s_WLAST, s_WVALID, s_WREADY, s_BVALID, s_BREADY;
  logic        grant, busy, wlast_err;

  int n_cmp = 0;
  int n_err = 0;

  axi_wr_arbiter #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .ARESETn(ARESETn),
    .m0_AWID(awid[0]), .m0_AWADDR(awaddr[0]), .m0_AWLEN(awlen[0]), .m0_AWSIZE(awsize[0]),
    .m0_AWBURST(awburst[0]), .m0_AWVALID(awvalid[0]), .m0_AWREADY(awready[0]),
    .m0_WID(wid[0]), .m0_WDATA(wdata[0]), .m0_WSTRB(wstrb[0]), .m0_WLAST(wlast[0]),
    .m0_WVALID(wvalid[0]), .m0_WREADY(wready[0]),
    .m0_BID(bid[0]), .m0_BRESP(bresp[0]), .m0_BVALID(bvalid[0]), .m0_BREADY(bready[0]),
    .m1_AWID(awid[1]), .m1_AWADDR(awaddr[1]), .m1_AWLEN(awlen[1]), .m1_AWSIZE(awsize[1]),
    .m1_AWBURST(awburst[1]), .m1_AWVALID(awvalid[1]), .m1_AWREADY(awready[1]),
    .m1_WID(wid[1]), .m1_WDATA(wdata[1]), .m1_WSTRB(wstrb[1]), .m1_WLAST(wlast[1]),
    .m1_WVALID(wvalid[1]), .m1_WREADY(wready[1]),
    .m1_BID(bid[1]), .m1_BRESP(bresp[1]), .m1_BVALID(bvalid[1]), .m1_BREADY(bready[1]),
    .s_AWID(s_AWID), .s_AWADDR(s_AWADDR), .s_AWLEN(s_AWLEN), .s_AWSIZE(s_AWSIZE),
    .s_AWBURST(s_AWBURST), .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
    .s_WID(s_WID), .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB), .s_WLAST(s_WLAST),
    .s_WVALID(s_WVALID), .s_WREADY(s_WREADY),
    .s_BID(s_BID), .s_BRESP(s_BRESP), .s_BVALID(s_BVALID), .s_BREADY(s_BREADY),
    .grant(grant), .busy(busy), .wlast_err(wlast_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Runs one granted transaction starting in the address phase.
  // bad >= 0 adds an early master WLAST on that beat index.
  task automatic txn(input int mi, input logic [7:0] len, input int bad, input logic [1:0] resp);
    int other = 1 - mi;
    #1;
    chk("aw_grant", 32'(grant), 32'(mi));
    chk("aw_busy", 32'(busy), 32'd1);
    chk("aw_svalid", 32'(s_AWVALID), 32'd1);
    chk("aw_id", 32'(s_AWID), 32'(awid[mi]));
    chk("aw_addr", s_AWADDR, awaddr[mi]);
    chk("aw_len", 32'(s_AWLEN), 32'(len));
    chk("aw_ready_wait", 32'(awready[mi]), 32'd0);
    chk("aw_wready_idle", 32'({wready[0], wready[1]}), 32'd0);
    s_AWREADY = 1'b1;
    #1;
    chk("aw_ready_owner", 32'(awready[mi]), 32'd1);
    chk("aw_ready_other", 32'(awready[other]), 32'd0);
    tick();
    awvalid[mi] = 1'b0;
    s_AWREADY   = 1'b0;
    s_WREADY    = 1'b1;
    wvalid[mi]  = 1'b1;
    wid[mi]     = awid[mi];
    for (int b = 0; b <= int'(len); b++) begin
      wdata[mi] = 32'hD000_0000 + 32'(mi * 65536) + 32'(b);
      wlast[mi] = (b == int'(len)) || (b == bad);
      #1;
      if (b == 0) chk("w_aw_dropped", 32'(s_AWVALID), 32'd0);
      chk("w_svalid", 32'(s_WVALID), 32'd1);
      chk("w_data", s_WDATA, 32'hD000_0000 + 32'(mi * 65536) + 32'(b));
      chk("w_id", 32'(s_WID), 32'(awid[mi]));
      chk("w_slast", 32'(s_WLAST), 32'(b == int'(len)));
      chk("w_err", 32'(wlast_err), 32'(b == bad));
      chk("w_ready_owner", 32'(wready[mi]), 32'd1);
      chk("w_ready_other", 32'(wready[other]), 32'd0);
      tick();
    end
    wvalid[mi] = 1'b0;
    wlast[mi]  = 1'b0;
    s_WREADY   = 1'b0;
    s_BVALID   = 1'b1;
    s_BID      = awid[mi];
    s_BRESP    = resp;
    bready[mi] = 1'b1;
    #1;
    chk("b_wvalid_off", 32'(s_WVALID), 32'd0);
    chk("b_busy", 32'(busy), 32'd1);
    chk("b_valid_owner", 32'(bvalid[mi]), 32'd1);
    chk("b_valid_other", 32'(bvalid[other]), 32'd0);
    chk("b_resp", 32'(bresp[mi]), 32'(resp));
    chk("b_id", 32'(bid[mi]), 32'(awid[mi]));
    chk("b_sready", 32'(s_BREADY), 32'd1);
    tick();
    s_BVALID   = 1'b0;
    bready[mi] = 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_awvalid", 32'(s_AWVALID), 32'd0);
    chk("idle_bready", 32'(s_BREADY), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    ARESETn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      awid[i] = 4'(i + 3); awaddr[i] = 32'h1000 + 32'(i * 32'h100);
      awlen[i] = 8'd0; awsize[i] = 3'd2; awburst[i] = 2'd1; awvalid[i] = 1'b0;
      wid[i] = 4'd0; wdata[i] = 32'd0; wstrb[i] = 4'hF; wlast[i] = 1'b0;
      wvalid[i] = 1'b0; bready[i] = 1'b0;
    end
    s_AWREADY = 1'b0; s_WREADY = 1'b0; s_BVALID = 1'b0; s_BID = 4'd0; s_BRESP = RespOkay;
    #3;
    chk("rst_awvalid", 32'(s_AWVALID), 32'd0);
    chk("rst_wvalid", 32'(s_WVALID), 32'd0);
    chk("rst_wlast", 32'(s_WLAST), 32'd0);
    chk("rst_bready", 32'(s_BREADY), 32'd0);
    chk("rst_m_ready", 32'({awready[0], awready[1], wready[0], wready[1]}), 32'd0);
    chk("rst_m_bvalid", 32'({bvalid[0], bvalid[1]}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_err", 32'(wlast_err), 32'd0);
    tick();
    ARESETn = 1'b1;
    tick();

    // Simultaneous requests from reset: m0, then m1, then m0 on the next tie.
    awvalid[0] = 1'b1; awlen[0] = 8'd3;
    awvalid[1] = 1'b1; awlen[1] = 8'd1;
    #1;
    chk("arb_latency", 32'(s_AWVALID), 32'd0);
    tick();
    txn(0, 8'd3, -1, RespOkay);
    tick();
    txn(1, 8'd1, -1, RespSlverr);
    awvalid[0] = 1'b1; awlen[0] = 8'd2;
    awvalid[1] = 1'b1; awlen[1] = 8'd0;
    tick();
    txn(0, 8'd2, 1, RespOkay);
    tick();
    txn(1, 8'd0, -1, RespOkay);

    // Slave WREADY toggling on an 8-beat burst.
    awvalid[0] = 1'b1; awlen[0] = 8'd7;
    tick();
    s_AWREADY = 1'b1;
    tick();
    awvalid[0] = 1'b0; s_AWREADY = 1'b0; wvalid[0] = 1'b1;
    beats = 0;
    for (int cyc = 0; cyc < 40 && beats < 8; cyc++) begin
      s_WREADY = cyc[0];
      wdata[0] = 32'hC0 + 32'(beats);
      wlast[0] = (beats == 7);
      #1;
      if (s_WREADY) begin
        chk("tog_data", s_WDATA, 32'hC0 + 32'(beats));
        chk("tog_slast", 32'(s_WLAST), 32'(beats == 7));
        chk("tog_err", 32'(wlast_err), 32'd0);
      end
      chk("tog_wready", 32'(wready[0]), 32'(s_WREADY));
      tick();
      if (s_WREADY) beats++;
    end
    wvalid[0] = 1'b0; wlast[0] = 1'b0; s_WREADY = 1'b0;
    #1;
    chk("tog_beats", 32'(beats), 32'd8);
    chk("tog_in_resp", 32'({busy, s_WVALID}), 32'b10);
    s_BVALID = 1'b1; bready[0] = 1'b1;
    #1;
    chk("tog_bvalid", 32'(bvalid[0]), 32'd1);
    tick();
    s_BVALID = 1'b0; bready[0] = 1'b0;

    // Asynchronous reset during beat 2 of a 6-beat burst.
    awvalid[0] = 1'b1; awlen[0] = 8'd5;
    tick();
    s_AWREADY = 1'b1;
    tick();
    awvalid[0] = 1'b0; s_AWREADY = 1'b0; wvalid[0] = 1'b1; s_WREADY = 1'b1;
    tick();
    #1;
    ARESETn = 1'b0;
    #1;
    chk("arst_wvalid", 32'(s_WVALID), 32'd0);
    chk("arst_wready", 32'(wready[0]), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_other", 32'({s_AWVALID, s_BREADY, awready[0], bvalid[0]}), 32'd0);
    wvalid[0] = 1'b0; s_WREADY = 1'b0;
    #1;
    ARESETn = 1'b1;
    awvalid[1] = 1'b1; awlen[1] = 8'd0;
    tick();
    txn(1, 8'd0, -1, RespOkay);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Two-to-one AXI write-path arbiter placed between two master-side AXI_IF write channels (AW/W/B) and one slave-side write port. It grants one master at a time with round-robin fairness. The grant is held for the whole transaction, from the address handshake through the data burst to the response handshake. The arbiter counts data beats against AWLEN and regenerates WLAST toward the slave. Read channels are not handled by this block.

## Interface
- ID_W, 4, width of AWID/WID/BID
- ADDR_W, 32, width of AWADDR
- DATA_W, 32, width of WDATA; WSTRB width is DATA_W/8
- clk  in  1  sole clock; all state updates on posedge
- ARESETn  in  1  asynchronous, active-low reset
- mN_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID (N=0,1)  in  ID_W/ADDR_W/8/3/2/1  master N write-address request
- mN_AWREADY  out  1  address accept to master N
- mN_WID/WDATA/WSTRB/WLAST/WVALID  in  ID_W/DATA_W/DATA_W/8/1/1  master N write data
- mN_WREADY  out  1  data accept to master N
- mN_BID/BRESP/BVALID  out  ID_W/2/1  response to master N
- mN_BREADY  in  1  master N response accept
- s_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  as master  muxed address to slave
- s_AWREADY  in  1  slave address accept
- s_WID/WDATA/WSTRB/WLAST/WVALID  out  as master  muxed data to slave; WLAST regenerated
- s_WREADY  in  1  slave data accept
- s_BID/BRESP/BVALID  in  ID_W/2/1  slave response
- s_BREADY  out  1  muxed response accept
- grant  out  1  index of current or last owner
- busy  out  1  high in any state other than IDLE
- wlast_err  out  1  one-cycle pulse on a master WLAST mismatch

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. Reset state is IDLE.
- IDLE:
  - If either mN_AWVALID=1, register grant and go to ADDR.
  - If both are valid, grant the master that is not `last`. `last` resets to 1, so m0 wins the first tie.
- ADDR:
  - s_AW* = granted master's AW* and s_AWVALID = its AWVALID.
  - Granted mN_AWREADY = s_AWREADY. The non-granted AWREADY is 0.
  - On handshake, load beat_cnt = AWLEN and go to DATA.
- DATA:
  - s_W* = granted master's W*. Granted mN_WREADY = s_WREADY.
  - s_WLAST = (beat_cnt==0). The master's WLAST is ignored for slave framing.
  - On each W handshake:
    - if beat_cnt!=0, decrement beat_cnt;
    - if beat_cnt==0, go to RESP.
  - wlast_err pulses on a W handshake where the master's WLAST != (beat_cnt==0).
- RESP:
  - Granted mN_B* = s_B*. s_BREADY = granted mN_BREADY. Non-granted mN_BVALID = 0.
  - On B handshake, set last = grant and go to IDLE.
- Exactly one transaction is outstanding. BID is passed through unchanged; no ID remapping.
- Non-granted master: AWREADY, WREADY and BVALID are held at 0 in every state.
- All slave-side valids are 0 in IDLE and in every state where that channel is inactive.

## Timing
- Reset values:
  - s_AWVALID, s_WVALID, s_BREADY, all mN_AWREADY/WREADY/BVALID = 0
  - s_WLAST = 0, busy = 0, grant = 0, wlast_err = 0
  - beat_cnt = 0, last = 1
- Arbitration latency: AWVALID seen in IDLE at edge k gives s_AWVALID=1 from cycle k+1.
- Forward paths are combinational muxes of registered state and inputs. READY/VALID signals are never registered, so there is no extra beat latency.
- Back-to-back: B handshake at edge k returns to IDLE; the next grant takes effect at k+1, and s_AWVALID is asserted from k+2.
- AWLEN=0 gives a single beat with s_WLAST=1 on the first beat.
- AWLEN=255 requires 256 beats; beat_cnt is 8 bits and never wraps.
- A master that drops AWVALID in ADDR (protocol violation) leaves the FSM in ADDR. There is no timeout.
- ARESETn assertion mid-burst forces IDLE asynchronously and drops all valids/readies immediately. The in-flight burst is abandoned.

## Structure
- Package axi_arb_pkg holds:
  - the state enum;
  - ID_W/ADDR_W/DATA_W defaults;
  - BRESP constants (OKAY=2'b00, SLVERR=2'b10).
- Sub-module rr_arb2: round-robin two-way grant logic from (req[1:0], last) to (gnt_idx, gnt_valid), instantiated once.

## Test plan
- m0 only, AWLEN=3, WLAST on beat 4, s_BRESP=OKAY -> 4 slave beats with s_WLAST only on beat 4, m0 gets BRESP=0, wlast_err stays 0, grant=0.
- m0 and m1 assert AWVALID in the same cycle from reset -> m0 served first, m1 next. A second simultaneous request after that is served m0 again, so ownership alternates m0,m1,m0.
- m1 burst AWLEN=0 while m0 is idle -> single beat with s_WLAST=1, next cycle in RESP, m0_WREADY=0 throughout.
- m0 AWLEN=2 but WLAST asserted on beat 2 -> wlast_err pulses 1 cycle on beat 2, s_WLAST=0 on beat 2 and 1 on beat 3, transaction completes normally.
- s_WREADY toggled 0/1 each cycle during AWLEN=7 burst -> exactly 8 handshakes, no beat duplicated or dropped, slave data matches master data in order.
- ARESETn pulled low during beat 2 of an AWLEN=5 burst -> all valids/readies 0 in the same cycle, busy=0. After release, a fresh m1 request is granted within 1 cycle.
